// File: rtl/dspi_pkg.sv
// Shared encodings, FSM state type and default widths
// for the DSPI stream arbiter slice.
package dspi_pkg;

    localparam int DEF_DATA_WIDTH        = 512;
    localparam int DEF_STREAM_ID_NUM     = 16;
    localparam int DEF_CHUNK_ID_NUM      = 32;
    localparam int DEF_CHANNEL_ID_NUM    = 1024;
    localparam int DEF_STATE_WIDTH       = 32;
    localparam int DEF_INSTR_WIDTH       = 2;
    localparam int DEF_INSTR_PARAM_WIDTH = 16;
    localparam int DEF_TIMEOUT_CYCLES    = 256;

    localparam logic [1:0] INSTRUCTION_CMD_IDLE    = 2'd0;
    localparam logic [1:0] INSTRUCTION_CMD_REQUEST = 2'd1;
    localparam logic [1:0] INSTRUCTION_CMD_REWIND  = 2'd2;
    localparam logic [1:0] INSTRUCTION_CMD_RESET   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dspi_timeout_counter.sv
// Idle-grant counter: clear wins over count, tc flags the
// last cycle before the limit is reached.
module dspi_timeout_counter #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dspi_stream_arbiter.sv
// Two-requester round-robin packet arbiter with registered
// forward path and downstream instruction routing.
module dspi_stream_arbiter
    import dspi_pkg::*;
#(
    parameter int DATA_WIDTH                  = DEF_DATA_WIDTH,
    parameter int STREAM_ID_NUM               = DEF_STREAM_ID_NUM,
    parameter int CHUNK_ID_NUM                = DEF_CHUNK_ID_NUM,
    parameter int CHANNEL_ID_NUM              = DEF_CHANNEL_ID_NUM,
    parameter int STATE_WIDTH                 = DEF_STATE_WIDTH,
    parameter int INSTRUCTION_WIDTH           = DEF_INSTR_WIDTH,
    parameter int INSTRUCTION_PARAMETER_WIDTH = DEF_INSTR_PARAM_WIDTH,
    parameter int TIMEOUT_CYCLES              = DEF_TIMEOUT_CYCLES,
    localparam int SW = $clog2(STREAM_ID_NUM),
    localparam int KW = $clog2(CHUNK_ID_NUM),
    localparam int CW = $clog2(CHANNEL_ID_NUM),
    localparam int IW = INSTRUCTION_WIDTH,
    localparam int PW = INSTRUCTION_PARAMETER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_Req,
    output logic                   req0_Grant,
    input  logic [DATA_WIDTH-1:0]  req0_Data,
    input  logic [1:0]             req0_Type,
    input  logic                   req0_Last,
    input  logic [SW-1:0]          req0_StreamID,
    input  logic [KW-1:0]          req0_ChunkID,
    input  logic [CW-1:0]          req0_ChannelID,
    input  logic [STATE_WIDTH-1:0] req0_State,
    input  logic                   req1_Req,
    output logic                   req1_Grant,
    input  logic [DATA_WIDTH-1:0]  req1_Data,
    input  logic [1:0]             req1_Type,
    input  logic                   req1_Last,
    input  logic [SW-1:0]          req1_StreamID,
    input  logic [KW-1:0]          req1_ChunkID,
    input  logic [CW-1:0]          req1_ChannelID,
    input  logic [STATE_WIDTH-1:0] req1_State,
    output logic [DATA_WIDTH-1:0]  out_Data,
    output logic [1:0]             out_Type,
    output logic                   out_Last,
    output logic [SW-1:0]          out_StreamID,
    output logic [KW-1:0]          out_ChunkID,
    output logic [CW-1:0]          out_ChannelID,
    output logic [STATE_WIDTH-1:0] out_State,
    input  logic [IW-1:0]          back_InstructionType,
    input  logic [SW-1:0]          back_InstructionStreamID,
    input  logic [CW-1:0]          back_InstructionChannelID,
    input  logic [PW-1:0]          back_InstructionParameter,
    output logic [IW-1:0]          req0_InstructionType,
    output logic [SW-1:0]          req0_InstructionStreamID,
    output logic [CW-1:0]          req0_InstructionChannelID,
    output logic [PW-1:0]          req0_InstructionParameter,
    output logic [IW-1:0]          req1_InstructionType,
    output logic [SW-1:0]          req1_InstructionStreamID,
    output logic [CW-1:0]          req1_InstructionChannelID,
    output logic [PW-1:0]          req1_InstructionParameter,
    output logic                   err_Timeout,
    output logic [15:0]            err_DropCount
);

    arb_state_e state_q, state_d;
    logic rr_q, rr_d;
    logic grant0_q, grant1_q;
    logic tmo_q, tmo_d;
    logic [15:0] drop_q, drop_d;

    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [1:0]             out_type_q, out_type_d;
    logic                   out_last_q, out_last_d;
    logic [SW-1:0]          out_sid_q, out_sid_d;
    logic [KW-1:0]          out_kid_q, out_kid_d;
    logic [CW-1:0]          out_cid_q, out_cid_d;
    logic [STATE_WIDTH-1:0] out_st_q, out_st_d;

    logic [IW-1:0] i0_type_q, i0_type_d, i1_type_q, i1_type_d;
    logic [SW-1:0] i_sid_q;
    logic [CW-1:0] i_cid_q;
    logic [PW-1:0] i_par_q;

    logic g0, g1, cur, beat_v, fwd, cmd_reset, tmo_tc;
    logic b_last, own_req, oth_req;
    logic drop0, drop1;
    logic [16:0] drop_sum;

    assign g0        = (state_q == ST_GRANT0);
    assign g1        = (state_q == ST_GRANT1);
    assign cur       = g1;
    assign b_last    = cur ? req1_Last : req0_Last;
    assign own_req   = cur ? req1_Req : req0_Req;
    assign oth_req   = cur ? req0_Req : req1_Req;
    assign beat_v    = (g0 && req0_Type != 2'd0) || (g1 && req1_Type != 2'd0);
    assign cmd_reset = (back_InstructionType == IW'(INSTRUCTION_CMD_RESET));
    // A reset command abandons the packet unless this beat closes it.
    assign fwd       = beat_v && (!cmd_reset || b_last);

    dspi_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clear  (!(g0 || g1) || beat_v || (state_d != state_q)),
        .enable (g0 || g1),
        .tc     (tmo_tc)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        tmo_d      = tmo_q;
        out_type_d = 2'd0;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        out_sid_d  = out_sid_q;
        out_kid_d  = out_kid_q;
        out_cid_d  = out_cid_q;
        out_st_d   = out_st_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req0_Req && req1_Req) begin
                    state_d = rr_q ? ST_GRANT1 : ST_GRANT0;
                end else if (req0_Req) begin
                    state_d = ST_GRANT0;
                end else if (req1_Req) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (beat_v) begin
                    if (b_last) begin
                        rr_d = ~cur;
                        if (oth_req) begin
                            state_d = cur ? ST_GRANT0 : ST_GRANT1;
                        end else if (!own_req) begin
                            state_d = ST_IDLE;
                        end
                    end
                end else if (tmo_tc) begin
                    state_d = ST_IDLE;
                    rr_d    = ~cur;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fwd) begin
            out_type_d = cur ? req1_Type : req0_Type;
            out_last_d = b_last;
            out_data_d = cur ? req1_Data : req0_Data;
            out_sid_d  = cur ? req1_StreamID : req0_StreamID;
            out_kid_d  = cur ? req1_ChunkID : req0_ChunkID;
            out_cid_d  = cur ? req1_ChannelID : req0_ChannelID;
            out_st_d   = cur ? req1_State : req0_State;
        end
        if (cmd_reset) begin
            state_d = ST_IDLE;
        end
    end

    assign drop0    = (req0_Type != 2'd0) && !g0;
    assign drop1    = (req1_Type != 2'd0) && !g1;
    assign drop_sum = {1'b0, drop_q} + 17'(drop0) + 17'(drop1);
    assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_comb begin
        i0_type_d = IW'(INSTRUCTION_CMD_IDLE);
        i1_type_d = IW'(INSTRUCTION_CMD_IDLE);
        if (cmd_reset) begin
            i0_type_d = back_InstructionType;
            i1_type_d = back_InstructionType;
        end else if (back_InstructionStreamID[SW-1]) begin
            i1_type_d = back_InstructionType;
        end else begin
            i0_type_d = back_InstructionType;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            grant0_q   <= 1'b0;
            grant1_q   <= 1'b0;
            tmo_q      <= 1'b0;
            drop_q     <= '0;
            out_type_q <= 2'd0;
            out_last_q <= 1'b0;
            i0_type_q  <= IW'(INSTRUCTION_CMD_IDLE);
            i1_type_q  <= IW'(INSTRUCTION_CMD_IDLE);
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant0_q   <= (state_d == ST_GRANT0);
            grant1_q   <= (state_d == ST_GRANT1);
            tmo_q      <= tmo_d;
            drop_q     <= drop_d;
            out_type_q <= out_type_d;
            out_last_q <= out_last_d;
            i0_type_q  <= i0_type_d;
            i1_type_q  <= i1_type_d;
        end
    end

    // Payload and instruction fields are qualified by their type.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
        out_sid_q  <= out_sid_d;
        out_kid_q  <= out_kid_d;
        out_cid_q  <= out_cid_d;
        out_st_q   <= out_st_d;
        i_sid_q    <= back_InstructionStreamID;
        i_cid_q    <= back_InstructionChannelID;
        i_par_q    <= back_InstructionParameter;
    end

    assign req0_Grant    = grant0_q;
    assign req1_Grant    = grant1_q;
    assign out_Data      = out_data_q;
    assign out_Type      = out_type_q;
    assign out_Last      = out_last_q;
    assign out_StreamID  = out_sid_q;
    assign out_ChunkID   = out_kid_q;
    assign out_ChannelID = out_cid_q;
    assign out_State     = out_st_q;
    assign err_Timeout   = tmo_q;
    assign err_DropCount = drop_q;

    assign req0_InstructionType      = i0_type_q;
    assign req0_InstructionStreamID  = i_sid_q;
    assign req0_InstructionChannelID = i_cid_q;
    assign req0_InstructionParameter = i_par_q;
    assign req1_InstructionType      = i1_type_q;
    assign req1_InstructionStreamID  = i_sid_q;
    assign req1_InstructionChannelID = i_cid_q;
    assign req1_InstructionParameter = i_par_q;

endmodule

// File: tb/tb_dspi_stream_arbiter.sv
// Directed scoreboard bench for dspi_stream_arbiter.
module tb_dspi_stream_arbiter;

    localparam int DW = 512;
    localparam int SW = 4;
    localparam int KW = 5;
    localparam int CW = 10;
    localparam int TW = 32;

    logic clk = 1'b0;
    logic rst;
    logic req0_Req, req1_Req, req0_Grant, req1_Grant;
    logic [DW-1:0] req0_Data, req1_Data, out_Data;
    logic [1:0] req0_Type, req1_Type, out_Type;
    logic req0_Last, req1_Last, out_Last;
    logic [SW-1:0] req0_StreamID, req1_StreamID, out_StreamID;
    logic [KW-1:0] req0_ChunkID, req1_ChunkID, out_ChunkID;
    logic [CW-1:0] req0_ChannelID, req1_ChannelID, out_ChannelID;
    logic [TW-1:0] req0_State, req1_State, out_State;
    logic [1:0] back_InstructionType;
    logic [SW-1:0] back_InstructionStreamID;
    logic [CW-1:0] back_InstructionChannelID;
    logic [15:0] back_InstructionParameter;
    logic [1:0] req0_InstructionType, req1_InstructionType;
    logic [SW-1:0] req0_InstructionStreamID, req1_InstructionStreamID;
    logic [CW-1:0] req0_InstructionChannelID, req1_InstructionChannelID;
    logic [15:0] req0_InstructionParameter, req1_InstructionParameter;
    logic err_Timeout;
    logic [15:0] err_DropCount;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [SW-1:0] sid;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dspi_stream_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_Req(req0_Req), .req0_Grant(req0_Grant),
        .req0_Data(req0_Data), .req0_Type(req0_Type),
        .req0_Last(req0_Last), .req0_StreamID(req0_StreamID),
        .req0_ChunkID(req0_ChunkID), .req0_ChannelID(req0_ChannelID),
        .req0_State(req0_State),
        .req1_Req(req1_Req), .req1_Grant(req1_Grant),
        .req1_Data(req1_Data), .req1_Type(req1_Type),
        .req1_Last(req1_Last), .req1_StreamID(req1_StreamID),
        .req1_ChunkID(req1_ChunkID), .req1_ChannelID(req1_ChannelID),
        .req1_State(req1_State),
        .out_Data(out_Data), .out_Type(out_Type), .out_Last(out_Last),
        .out_StreamID(out_StreamID), .out_ChunkID(out_ChunkID),
        .out_ChannelID(out_ChannelID), .out_State(out_State),
        .back_InstructionType(back_InstructionType),
        .back_InstructionStreamID(back_InstructionStreamID),
        .back_InstructionChannelID(back_InstructionChannelID),
        .back_InstructionParameter(back_InstructionParameter),
        .req0_InstructionType(req0_InstructionType),
        .req0_InstructionStreamID(req0_InstructionStreamID),
        .req0_InstructionChannelID(req0_InstructionChannelID),
        .req0_InstructionParameter(req0_InstructionParameter),
        .req1_InstructionType(req1_InstructionType),
        .req1_InstructionStreamID(req1_InstructionStreamID),
        .req1_InstructionChannelID(req1_InstructionChannelID),
        .req1_InstructionParameter(req1_InstructionParameter),
        .err_Timeout(err_Timeout), .err_DropCount(err_DropCount)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_Type = 2'd0;
        req1_Type = 2'd0;
        req0_Last = 1'b0;
        req1_Last = 1'b0;
    endtask

    task automatic send(input int p, input logic [31:0] tag,
                        input logic last, input bit push);
        logic [DW-1:0] d;
        exp_t e;
        d = {16{tag}};
        if (p == 0) begin
            req0_Type = 2'd1; req0_Data = d; req0_Last = last;
            req0_StreamID = SW'(tag); req1_Type = 2'd0;
        end else begin
            req1_Type = 2'd1; req1_Data = d; req1_Last = last;
            req1_StreamID = SW'(tag); req0_Type = 2'd0;
        end
        if (push) begin
            e.data = d; e.last = last; e.sid = SW'(tag);
            sb.push_back(e);
        end
    endtask

    // Output monitor: every forwarded beat must match the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_Type != 2'd0) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_beat got=%0h exp=none",
                       out_Data[31:0]);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                assert ({out_Data, out_Last, out_StreamID} ===
                        {e.data, e.last, e.sid}) else begin
                    bad++;
                    $error("FAIL beat got=%0h/%0b exp=%0h/%0b",
                           out_Data[31:0], out_Last,
                           e.data[31:0], e.last);
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        req0_Req = 0; req1_Req = 0;
        req0_Data = '0; req1_Data = '0;
        req0_StreamID = '0; req1_StreamID = '0;
        req0_ChunkID = 5'd3; req1_ChunkID = 5'd7;
        req0_ChannelID = '0; req1_ChannelID = '0;
        req0_State = '0; req1_State = '0;
        back_InstructionType = 2'd0;
        back_InstructionStreamID = '0;
        back_InstructionChannelID = '0;
        back_InstructionParameter = '0;
        idle();
        tick();
        tick();
        chk("rst_g0", req0_Grant, 0);
        chk("rst_g1", req1_Grant, 0);
        chk("rst_otype", out_Type, 0);
        chk("rst_olast", out_Last, 0);
        chk("rst_tmo", err_Timeout, 0);
        chk("rst_drop", err_DropCount, 0);
        chk("rst_i0", req0_InstructionType, 0);
        chk("rst_i1", req1_InstructionType, 0);
        rst = 1'b0;

        // Both request from reset: req0 first, req1 without a bubble.
        req0_Req = 1; req1_Req = 1;
        tick();
        chk("t1_g0", req0_Grant, 1);
        chk("t1_g1", req1_Grant, 0);
        send(0, 32'hA001, 0, 1); tick();
        chk("t1_v1", out_Type, 1);
        send(0, 32'hA002, 0, 1); tick();
        chk("t1_v2", out_Type, 1);
        send(0, 32'hA003, 1, 1); req0_Req = 0; tick();
        chk("t1_v3", out_Type, 1);
        chk("t1_sw_g1", req1_Grant, 1);
        chk("t1_sw_g0", req0_Grant, 0);
        send(1, 32'hB001, 0, 1); tick();
        chk("t1_v4", out_Type, 1);
        send(1, 32'hB002, 0, 1); tick();
        chk("t1_v5", out_Type, 1);
        send(1, 32'hB003, 1, 1); req1_Req = 0; tick();
        chk("t1_v6", out_Type, 1);
        chk("t1_end_g0", req0_Grant, 0);
        chk("t1_end_g1", req1_Grant, 0);
        idle();

        // req0 back-to-back while req1 waits: req0, req1, req0.
        req0_Req = 1; req1_Req = 1;
        tick();
        chk("t2_g0a", req0_Grant, 1);
        send(0, 32'hC001, 0, 1); tick();
        send(0, 32'hC002, 1, 1); tick();
        chk("t2_g1", req1_Grant, 1);
        send(1, 32'hD001, 1, 1); req1_Req = 0; tick();
        chk("t2_g0b", req0_Grant, 1);
        send(0, 32'hC003, 1, 1); req0_Req = 0; tick();
        chk("t2_end", {req0_Grant, req1_Grant}, 0);
        idle();

        // Beat on the non-granted port is dropped and counted.
        req0_Req = 1;
        tick();
        chk("t3_g0", req0_Grant, 1);
        send(1, 32'hEEEE, 0, 0); tick();
        chk("t3_nofwd", out_Type, 0);
        chk("t3_drop", err_DropCount, 1);
        send(0, 32'hE001, 1, 1); req0_Req = 0; tick();
        idle();
        tick();

        // Silent grant times out after the idle limit.
        req0_Req = 1;
        tick();
        chk("t4_g0", req0_Grant, 1);
        req1_Req = 1;
        n = 1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (req0_Grant !== 1'b1) break;
            n++;
        end
        chk("t4_len", n, 256);
        chk("t4_tmo", err_Timeout, 1);
        chk("t4_g0_off", req0_Grant, 0);
        req0_Req = 0;
        tick();
        chk("t4_g1", req1_Grant, 1);

        // Reset command mid-packet on req1.
        send(1, 32'hF001, 0, 1); tick();
        send(1, 32'hF002, 0, 0);
        back_InstructionType = 2'd3;
        tick();
        chk("t5_g1", req1_Grant, 0);
        chk("t5_otype", out_Type, 0);
        chk("t5_i0", req0_InstructionType, 3);
        chk("t5_i1", req1_InstructionType, 3);
        back_InstructionType = 2'd0;
        req1_Req = 0;
        idle();
        tick();
        chk("t5_i0_idle", req0_InstructionType, 0);
        chk("t5_tmo_sticky", err_Timeout, 1);

        // Instruction routed by stream-ID MSB.
        back_InstructionType = 2'd1;
        back_InstructionStreamID = 4'b1010;
        back_InstructionChannelID = 10'h155;
        back_InstructionParameter = 16'h0008;
        tick();
        chk("t6_i1", req1_InstructionType, 1);
        chk("t6_i1_sid", req1_InstructionStreamID, 4'b1010);
        chk("t6_i1_cid", req1_InstructionChannelID, 10'h155);
        chk("t6_i1_par", req1_InstructionParameter, 16'h0008);
        chk("t6_i0", req0_InstructionType, 0);
        back_InstructionType = 2'd0;
        tick();
        chk("t6_i1_idle", req1_InstructionType, 0);

        // Reset command coinciding with a Last beat.
        req0_Req = 1;
        tick();
        chk("t7_g0", req0_Grant, 1);
        send(0, 32'h7777, 1, 1);
        req0_Req = 0;
        back_InstructionType = 2'd3;
        back_InstructionStreamID = 4'b0000;
        tick();
        chk("t7_olast", {out_Type, out_Last}, 3'b011);
        chk("t7_g0_off", req0_Grant, 0);
        back_InstructionType = 2'd0;
        idle();
        tick();

        // Synchronous reset mid-packet.
        req0_Req = 1;
        tick();
        chk("t8_g0", req0_Grant, 1);
        send(0, 32'h8888, 0, 0);
        rst = 1'b1;
        tick();
        chk("t8_g0_off", req0_Grant, 0);
        chk("t8_otype", out_Type, 0);
        chk("t8_tmo", err_Timeout, 0);
        chk("t8_drop", err_DropCount, 0);
        rst = 1'b0;
        req0_Req = 0;
        idle();
        tick();
        tick();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
